// File: rtl/bridge_pkg.sv
// Shared constants for the CPU-to-timer bridge: FSM encoding,
// timer register offsets, default device bases and the window decoder.
package bridge_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam logic [31:0] BASE0_DEF = 32'h0000_7F00;
  localparam logic [31:0] BASE1_DEF = 32'h0000_7F10;

  // A device owns three word registers starting at its base.
  function automatic logic in_window(
    input logic [31:0] a,
    input logic [31:0] base
  );
    return (a >= base) && (a <= base + 32'd11) && (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dev_bridge_irq_pend.sv
// Rising-edge detector with a sticky pending flag for one device IRQ.
// Ports: CLK, RSTn (sync, active-low), irq level, ack pulse, pend out.
module irq_pend (
  input  logic CLK,
  input  logic RSTn,
  input  logic irq,
  input  logic ack,
  output logic pend
);

  logic irq_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_q <= irq;
      // a fresh edge wins over a simultaneous ack
      if (irq && !irq_q)
        pend <= 1'b1;
      else if (ack)
        pend <= 1'b0;
    end
  end

endmodule

// File: rtl/dev_bridge.sv
// CPU bus to two timer devices: IDLE/ACCESS/RESP access FSM, address
// decode, one-cycle ready strobe and per-device pending interrupts.
// Ports: Pr* CPU side, DEV* device side, IRQ*/IntAck in, HWInt to CP0.
module dev_bridge
  import bridge_pkg::*;
#(
  parameter logic [31:0] BASE0 = BASE0_DEF,
  parameter logic [31:0] BASE1 = BASE1_DEF
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        PrReq,
  input  logic        PrWE,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  output logic [31:0] PrRD,
  output logic        PrReady,
  output logic        PrErr,
  output logic [1:0]  DEV_innerADDR,
  output logic [31:0] DEV_WD,
  output logic        DEV0_WE,
  output logic        DEV1_WE,
  input  logic [31:0] DEV0_RD,
  input  logic [31:0] DEV1_RD,
  input  logic        IRQ0,
  input  logic        IRQ1,
  input  logic [1:0]  IntAck,
  output logic [5:0]  HWInt
);

  logic [1:0]  state;
  logic [31:0] addr_r;
  logic [31:0] wd_r;
  logic        we_r;
  logic [31:0] rd_r;
  logic        hit0;
  logic        hit1;
  logic        active;
  logic        pend0;
  logic        pend1;

  assign hit0   = in_window(addr_r, BASE0);
  assign hit1   = in_window(addr_r, BASE1);
  assign active = (state == S_ACCESS) || (state == S_RESP);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state  <= S_IDLE;
      addr_r <= '0;
      wd_r   <= '0;
      we_r   <= 1'b0;
      rd_r   <= '0;
    end else begin
      unique case (1'b1)
        (state == S_ACCESS): begin
          state <= S_RESP;
          if (!we_r && hit0)
            rd_r <= DEV0_RD;
          else if (!we_r && hit1)
            rd_r <= DEV1_RD;
          else
            rd_r <= '0;
        end
        (state == S_RESP): state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          if (PrReq) begin
            state  <= S_ACCESS;
            addr_r <= PrAddr;
            wd_r   <= PrWD;
            we_r   <= PrWE;
          end
        end
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, so an
  // in-flight access never leaks a write enable or ready.
  always_comb begin
    DEV_innerADDR = '0;
    DEV_WD        = '0;
    DEV0_WE       = 1'b0;
    DEV1_WE       = 1'b0;
    PrReady       = 1'b0;
    PrErr         = 1'b0;
    PrRD          = '0;
    if (RSTn) begin
      if (active) begin
        DEV_innerADDR = addr_r[3:2];
        DEV_WD        = wd_r;
      end
      if (state == S_ACCESS && we_r) begin
        DEV0_WE = hit0;
        DEV1_WE = hit1;
      end
      if (state == S_RESP) begin
        PrReady = 1'b1;
        PrErr   = !(hit0 || hit1);
        PrRD    = rd_r;
      end
    end
  end

  irq_pend u_pend0 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .irq  (IRQ0),
    .ack  (IntAck[0]),
    .pend (pend0)
  );

  irq_pend u_pend1 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .irq  (IRQ1),
    .ack  (IntAck[1]),
    .pend (pend1)
  );

  assign HWInt = RSTn ? {4'b0000, pend1, pend0} : 6'b0;

endmodule

// File: tb/tb_dev_bridge.sv
// Directed self-checking bench for dev_bridge.
// Inputs change 1ns after a rising edge; outputs sampled on falling edges.
module tb_dev_bridge;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        PrReq;
  logic        PrWE;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic [31:0] PrRD;
  logic        PrReady;
  logic        PrErr;
  logic [1:0]  DEV_innerADDR;
  logic [31:0] DEV_WD;
  logic        DEV0_WE;
  logic        DEV1_WE;
  logic [31:0] DEV0_RD;
  logic [31:0] DEV1_RD;
  logic        IRQ0;
  logic        IRQ1;
  logic [1:0]  IntAck;
  logic [5:0]  HWInt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Device read models: simple functions of the register select.
  assign DEV0_RD = 32'hA5A5_0000 | {30'd0, DEV_innerADDR};
  assign DEV1_RD = (DEV_innerADDR == 2'd2) ? 32'h0000_1234
                 : (32'hDEAD_0000 | {30'd0, DEV_innerADDR});

  dev_bridge dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .PrReq         (PrReq),
    .PrWE          (PrWE),
    .PrAddr        (PrAddr),
    .PrWD          (PrWD),
    .PrRD          (PrRD),
    .PrReady       (PrReady),
    .PrErr         (PrErr),
    .DEV_innerADDR (DEV_innerADDR),
    .DEV_WD        (DEV_WD),
    .DEV0_WE       (DEV0_WE),
    .DEV1_WE       (DEV1_WE),
    .DEV0_RD       (DEV0_RD),
    .DEV1_RD       (DEV1_RD),
    .IRQ0          (IRQ0),
    .IRQ1          (IRQ1),
    .IntAck        (IntAck),
    .HWInt         (HWInt)
  );

  // Runs one access and reports what was observed (no checking here).
  // lat = falling-edge index after the accept edge where PrReady seen.
  task automatic do_access(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          lat,
    output logic [31:0] rd,
    output logic        err,
    output int          we0n,
    output int          we1n,
    output logic [1:0]  ia,
    output logic [31:0] dwd,
    output logic        rdnz
  );
    lat = -1; rd = '0; err = 1'b0; we0n = 0; we1n = 0;
    ia = '0; dwd = '0; rdnz = 1'b0;
    @(posedge CLK); #1;
    PrReq = 1'b1; PrWE = we; PrAddr = a; PrWD = d;
    @(posedge CLK); #1;
    PrReq = 1'b0; PrWE = 1'b0; PrAddr = '0; PrWD = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      if (DEV0_WE) we0n++;
      if (DEV1_WE) we1n++;
      if (c == 1) begin
        ia  = DEV_innerADDR;
        dwd = DEV_WD;
      end
      if (PrReady && lat < 0) begin
        lat = c;
        rd  = PrRD;
        err = PrErr;
      end else if (PrRD !== 32'd0) begin
        rdnz = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    RSTn = 1'b0; PrReq = 1'b0; PrWE = 1'b0; PrAddr = '0; PrWD = '0;
    IRQ0 = 1'b0; IRQ1 = 1'b0; IntAck = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({PrReady, PrErr, PrRD, DEV0_WE, DEV1_WE, DEV_innerADDR,
         DEV_WD, HWInt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h we=%b%b ia=%0d wd=%h hw=%b, want all 0",
               PrReady, PrErr, PrRD, DEV1_WE, DEV0_WE, DEV_innerADDR, DEV_WD, HWInt);
    end
    @(posedge CLK); #1; RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({PrReady, PrRD, DEV0_WE, DEV1_WE, HWInt} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b rd=%h we=%b%b hw=%b, want 0",
               PrReady, PrRD, DEV1_WE, DEV0_WE, HWInt);
    end
  endtask

  task automatic test_write_hit;
    int lat, w0, w1; logic [31:0] rd, dwd; logic err, nz; logic [1:0] ia;
    do_access(1'b1, 32'h7F00, 32'h0000_000B, lat, rd, err, w0, w1, ia, dwd, nz);
    checks++;
    if (lat !== 2) begin errors++;
      $display("FAIL wr0_latency: got %0d want 2", lat); end
    checks++;
    if (w0 !== 1 || w1 !== 0) begin errors++;
      $display("FAIL wr0_we: we0=%0d we1=%0d want 1 0", w0, w1); end
    checks++;
    if (ia !== 2'd0 || dwd !== 32'hB) begin errors++;
      $display("FAIL wr0_devbus: ia=%0d wd=%h want 0 0000000b", ia, dwd); end
    checks++;
    if (err !== 1'b0 || rd !== 32'd0 || nz) begin errors++;
      $display("FAIL wr0_resp: err=%b rd=%h nz=%b want 0 0 0", err, rd, nz); end
    // top word of device 0 window is still a hit
    do_access(1'b1, 32'h7F08, 32'hCAFE_0001, lat, rd, err, w0, w1, ia, dwd, nz);
    checks++;
    if (w0 !== 1 || w1 !== 0 || ia !== 2'd2 || err !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL wr0_edge: we0=%0d we1=%0d ia=%0d err=%b lat=%0d want 1 0 2 0 2",
               w0, w1, ia, err, lat);
    end
  endtask

  task automatic test_read_hit;
    int lat, w0, w1; logic [31:0] rd, dwd; logic err, nz; logic [1:0] ia;
    do_access(1'b0, 32'h7F18, 32'hFFFF_FFFF, lat, rd, err, w0, w1, ia, dwd, nz);
    checks++;
    if (rd !== 32'h1234 || err !== 1'b0 || lat !== 2) begin errors++;
      $display("FAIL rd1: rd=%h err=%b lat=%0d want 00001234 0 2", rd, err, lat); end
    checks++;
    if (w0 !== 0 || w1 !== 0 || nz) begin errors++;
      $display("FAIL rd1_nowe: we0=%0d we1=%0d nz=%b want 0 0 0", w0, w1, nz); end
    do_access(1'b0, 32'h7F04, 32'h0, lat, rd, err, w0, w1, ia, dwd, nz);
    checks++;
    if (rd !== 32'hA5A5_0001 || err !== 1'b0 || ia !== 2'd1) begin errors++;
      $display("FAIL rd0: rd=%h err=%b ia=%0d want a5a50001 0 1", rd, err, ia); end
  endtask

  task automatic test_miss;
    logic [31:0] addrs [4];
    logic        wes   [4];
    int lat, w0, w1; logic [31:0] rd, dwd; logic err, nz; logic [1:0] ia;
    addrs[0] = 32'h7F0C; wes[0] = 1'b1;
    addrs[1] = 32'h7F02; wes[1] = 1'b1;
    addrs[2] = 32'h8000; wes[2] = 1'b0;
    addrs[3] = 32'h7F1C; wes[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_access(wes[i], addrs[i], 32'h5555_AAAA, lat, rd, err, w0, w1, ia, dwd, nz);
      checks++;
      if (err !== 1'b1 || rd !== 32'd0 || w0 !== 0 || w1 !== 0 || lat !== 2) begin
        errors++;
        $display("FAIL miss_%h: err=%b rd=%h we0=%0d we1=%0d lat=%0d want 1 0 0 0 2",
                 addrs[i], err, rd, w0, w1, lat);
      end
    end
  endtask

  task automatic test_irq;
    int lat, w0, w1; logic [31:0] rd, dwd; logic err, nz; logic [1:0] ia;
    @(posedge CLK); #1; IRQ0 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (HWInt !== 6'b000001) begin errors++;
      $display("FAIL irq0_set: got %b want 000001", HWInt); end
    // clearing the timer CTRL must not touch the pending flag
    do_access(1'b1, 32'h7F00, 32'h0, lat, rd, err, w0, w1, ia, dwd, nz);
    checks++;
    if (HWInt !== 6'b000001) begin errors++;
      $display("FAIL irq0_ctrl_write: got %b want 000001", HWInt); end
    @(posedge CLK); #1; IntAck = 2'b01;
    @(posedge CLK); #1; IntAck = 2'b00;
    @(negedge CLK);
    checks++;
    if (HWInt !== 6'b000000) begin errors++;
      $display("FAIL irq0_ack: got %b want 000000", HWInt); end
    repeat (3) @(negedge CLK);
    checks++;
    if (HWInt !== 6'b000000) begin errors++;
      $display("FAIL irq0_level_held: got %b want 000000", HWInt); end
    @(posedge CLK); #1; IRQ0 = 1'b0;
    @(posedge CLK); #1; IRQ1 = 1'b1; IntAck = 2'b10;
    @(posedge CLK); #1; IntAck = 2'b00;
    @(negedge CLK);
    checks++;
    if (HWInt !== 6'b000010) begin errors++;
      $display("FAIL irq1_set_wins: got %b want 000010", HWInt); end
    @(posedge CLK); #1; IntAck = 2'b10;
    @(posedge CLK); #1; IntAck = 2'b00; IRQ1 = 1'b0;
    @(negedge CLK);
    checks++;
    if (HWInt !== 6'b000000) begin errors++;
      $display("FAIL irq1_ack: got %b want 000000", HWInt); end
  endtask

  task automatic test_back_to_back;
    int r1, r2, w1n;
    r1 = -1; r2 = -1; w1n = 0;
    @(posedge CLK); #1;
    PrReq = 1'b1; PrWE = 1'b1; PrAddr = 32'h7F14; PrWD = 32'h77;
    @(posedge CLK);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (DEV1_WE && r2 < 0) w1n++;
      if (PrReady) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
    end
    @(posedge CLK); #1; PrReq = 1'b0; PrWE = 1'b0; PrAddr = '0; PrWD = '0;
    repeat (4) @(posedge CLK);
    checks++;
    if (r1 !== 2 || r2 !== 5) begin errors++;
      $display("FAIL b2b_ready: first=%0d second=%0d want 2 5", r1, r2); end
    checks++;
    if (w1n !== 2) begin errors++;
      $display("FAIL b2b_we1: got %0d want 2", w1n); end
  endtask

  task automatic test_reset_in_flight;
    int rdy, wen, lat, w0, w1;
    logic [31:0] rd, dwd; logic err, nz; logic [1:0] ia;
    rdy = 0; wen = 0;
    @(posedge CLK); #1; IRQ0 = 1'b1;
    @(posedge CLK); #1; IRQ0 = 1'b0;
    @(posedge CLK); #1;
    PrReq = 1'b1; PrWE = 1'b1; PrAddr = 32'h7F04; PrWD = 32'h99;
    @(posedge CLK); #1;
    PrReq = 1'b0; PrWE = 1'b0; PrAddr = '0; PrWD = '0;
    RSTn = 1'b0;
    @(negedge CLK);
    if (DEV0_WE || DEV1_WE) wen++;
    @(posedge CLK); #1; RSTn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (PrReady) rdy++;
      if (DEV0_WE || DEV1_WE) wen++;
    end
    checks++;
    if (rdy !== 0 || wen !== 0) begin errors++;
      $display("FAIL rst_inflight: ready=%0d we=%0d want 0 0", rdy, wen); end
    checks++;
    if (HWInt !== 6'b000000) begin errors++;
      $display("FAIL rst_hwint: got %b want 000000", HWInt); end
    do_access(1'b1, 32'h7F14, 32'h42, lat, rd, err, w0, w1, ia, dwd, nz);
    checks++;
    if (lat !== 2 || w1 !== 1 || w0 !== 0 || err !== 1'b0 || dwd !== 32'h42) begin
      errors++;
      $display("FAIL rst_next_access: lat=%0d we0=%0d we1=%0d err=%b wd=%h want 2 0 1 0 42",
               lat, w0, w1, err, dwd);
    end
  endtask

  initial begin
    test_reset;
    test_write_hit;
    test_read_hit;
    test_miss;
    test_irq;
    test_back_to_back;
    test_reset_in_flight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
